// File: rtl/color_pkg.sv
// rtl/color_pkg.sv - shared types and encodings for the Color FSM and its driver
//
// Contents:
//   Color_state   : decoded peer colour (Blue=0, Red=1)
//   CMD_*         : command codes driven onto the peer's `in` bus
//   OUT_*         : legal codes seen on the peer's `out` bus
//   drv_state_e   : driver state encoding (IDLE, PULSE, WAIT, DONE)
//   out_is_legal  : true when a peer `out` code is one of the two legal colours

package color_pkg;

    typedef enum logic {
        Blue = 1'b0,
        Red  = 1'b1
    } Color_state;

    localparam logic [1:0] CMD_TOGGLE = 2'h1;
    localparam logic [1:0] CMD_NOP    = 2'h3;

    localparam logic [1:0] OUT_BLUE   = 2'h1;
    localparam logic [1:0] OUT_RED    = 2'h2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } drv_state_e;

    function automatic logic out_is_legal(input logic [1:0] code);
        return (code == OUT_BLUE) || (code == OUT_RED);
    endfunction

endpackage

// File: rtl/color_out_decoder.sv
// rtl/color_out_decoder.sv - combinational decode of the Color FSM `out` bus
//
// Ports:
//   i_fsm_out : peer `out` code
//   o_legal   : 1 when i_fsm_out is Blue (2'h1) or Red (2'h2)
//   o_color   : decoded colour (0 = Blue, 1 = Red); only meaningful when o_legal

module color_out_decoder
    import color_pkg::*;
(
    input  logic [1:0] i_fsm_out,
    output logic       o_legal,
    output logic       o_color
);

    assign o_legal = out_is_legal(i_fsm_out);
    assign o_color = (i_fsm_out == OUT_RED) ? Red : Blue;

endmodule

// File: rtl/color_fsm_driver.sv
// rtl/color_fsm_driver.sv - request-driven initiator that steers the Color FSM to a target colour
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   req_valid  : request present
//   req_color  : target colour (0 = Blue, 1 = Red)
//   req_ready  : driver is idle and can accept a request
//   fsm_in     : command to the peer (2'h1 toggle, 2'h3 nop)
//   fsm_out    : peer output (2'h1 Blue, 2'h2 Red, others illegal)
//   done_valid : one-cycle completion pulse
//   done_err   : qualifies done_valid; 1 = timeout or illegal peer output
//   cur_color  : last legal colour seen on fsm_out
//   busy       : driver is not idle

module color_fsm_driver
    import color_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_color,
    output logic       req_ready,
    output logic [1:0] fsm_in,
    input  logic [1:0] fsm_out,
    output logic       done_valid,
    output logic       done_err,
    output logic       cur_color,
    output logic       busy
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_PULSE = ST_PULSE;
    localparam logic [1:0] S_WAIT  = ST_WAIT;
    localparam logic [1:0] S_DONE  = ST_DONE;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_target;
    logic          w_target_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_err_nxt;

    logic [1:0]    r_fsm_in;
    logic          r_req_ready;
    logic          r_done_valid;
    logic          r_done_err;
    logic          r_busy;
    logic          r_cur_color;

    logic          w_legal;
    logic          w_color;

    color_out_decoder u_dec (
        .i_fsm_out (fsm_out),
        .o_legal   (w_legal),
        .o_color   (w_color)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_cnt_nxt    = r_cnt;
        w_err_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_target_nxt = req_color;
                    if (!w_legal) begin
                        w_state_nxt = S_DONE;
                        w_err_nxt   = 1'b1;
                    end else if (w_color == req_color) begin
                        // Already there: finish without disturbing the peer.
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_PULSE;
                    end
                end
            end

            S_PULSE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT;
            end

            S_WAIT: begin
                if (w_legal && (w_color == r_target)) begin
                    w_state_nxt = S_DONE;
                end else if (!w_legal || (r_cnt == CNT_LAST)) begin
                    w_state_nxt = S_DONE;
                    w_err_nxt   = 1'b1;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so that none of them has a
    // combinational path from req_valid or fsm_out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_target     <= 1'b0;
            r_cnt        <= '0;
            r_fsm_in     <= CMD_NOP;
            r_req_ready  <= 1'b1;
            r_done_valid <= 1'b0;
            r_done_err   <= 1'b0;
            r_busy       <= 1'b0;
            r_cur_color  <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_target     <= w_target_nxt;
            r_cnt        <= w_cnt_nxt;
            r_fsm_in     <= (w_state_nxt == S_PULSE) ? CMD_TOGGLE : CMD_NOP;
            r_req_ready  <= (w_state_nxt == S_IDLE);
            r_done_valid <= (w_state_nxt == S_DONE);
            r_done_err   <= (w_state_nxt == S_DONE) && w_err_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            if (w_legal) begin
                r_cur_color <= w_color;
            end
        end
    end

    assign fsm_in     = r_fsm_in;
    assign req_ready  = r_req_ready;
    assign done_valid = r_done_valid;
    assign done_err   = r_done_err;
    assign busy       = r_busy;
    assign cur_color  = r_cur_color;

endmodule
